// File: rtl/asic_dma_feeder.sv
// DMA engine that streams input words from memory into the ASIC wrapper DATA register,
// waits for the ASIC interrupt, then drains OFMAP words back to memory over one AXI4 master.
module asic_dma_feeder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 11
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W-1:0]   asic_base,
  input  logic [CNT_W-1:0]    in_words,
  input  logic [7:0]          out_words,
  input  logic                asic_irq,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [3:0]          AWID,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [3:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [3:0]          BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic [3:0]          ARID,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [3:0]          ARLEN,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [3:0]          RID,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY
);

  typedef enum logic [3:0] {
    IDLE, IN_AR, IN_R, IN_AW, IN_W, IN_B, WAIT_IRQ,
    OUT_AR, OUT_R, OUT_AW, OUT_W, OUT_B, FIN
  } state_t;

  localparam logic [ADDR_W-1:0] DATA_OFS  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] OFMAP_OFS = ADDR_W'(8);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] src_q, dst_q, base_q;
  logic [CNT_W-1:0]  in_words_q, in_cnt, in_cnt_inc;
  logic [7:0]        out_words_q, out_cnt, out_cnt_inc;
  logic              ar_hs, r_hs, aw_hs, w_hs, b_hs, r_bad, b_bad, in_last, out_last;
  logic              unused_ok;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [ADDR_W-1:0] idx);
    return base + (idx << 2);
  endfunction

  assign ar_hs       = ARVALID & ARREADY;
  assign r_hs        = RVALID & RREADY;
  assign aw_hs       = AWVALID & AWREADY;
  assign w_hs        = WVALID & WREADY;
  assign b_hs        = BVALID & BREADY;
  assign r_bad       = r_hs & (RRESP != 2'b00);
  assign b_bad       = b_hs & (BRESP != 2'b00);
  assign in_cnt_inc  = in_cnt + CNT_W'(1);
  assign out_cnt_inc = out_cnt + 8'd1;
  assign in_last     = (in_cnt_inc == in_words_q);
  assign out_last    = (out_cnt_inc == out_words_q);

  assign AWID    = 4'd0;
  assign ARID    = 4'd0;
  assign AWLEN   = 4'd0;
  assign ARLEN   = 4'd0;
  assign AWSIZE  = 3'b010;
  assign ARSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign ARBURST = 2'b01;
  assign WSTRB   = '1;
  assign WLAST   = WVALID;
  assign unused_ok = ^{BID, RID, RLAST};

  always_ff @(posedge ACLK) begin
    if (!ARESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Handshake outputs depend only on the state, so VALID holds steady until its handshake.
  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    BREADY    = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (in_words != '0)       state_nxt = IN_AR;
          else if (out_words != '0) state_nxt = WAIT_IRQ;
          else                      state_nxt = FIN;
        end
      end
      IN_AR: begin
        ARVALID = 1'b1;
        if (ar_hs) state_nxt = IN_R;
      end
      IN_R: begin
        RREADY = 1'b1;
        if (r_bad)     state_nxt = FIN;
        else if (r_hs) state_nxt = IN_AW;
      end
      IN_AW: begin
        AWVALID = 1'b1;
        if (aw_hs) state_nxt = IN_W;
      end
      IN_W: begin
        WVALID = 1'b1;
        if (w_hs) state_nxt = IN_B;
      end
      IN_B: begin
        BREADY = 1'b1;
        if (b_bad)                state_nxt = FIN;
        else if (b_hs && !in_last) state_nxt = IN_AR;
        else if (b_hs)            state_nxt = (out_words_q != '0) ? WAIT_IRQ : FIN;
      end
      WAIT_IRQ: begin
        if (asic_irq) state_nxt = OUT_AR;
      end
      OUT_AR: begin
        ARVALID = 1'b1;
        if (ar_hs) state_nxt = OUT_R;
      end
      OUT_R: begin
        RREADY = 1'b1;
        if (r_bad)     state_nxt = FIN;
        else if (r_hs) state_nxt = OUT_AW;
      end
      OUT_AW: begin
        AWVALID = 1'b1;
        if (aw_hs) state_nxt = OUT_W;
      end
      OUT_W: begin
        WVALID = 1'b1;
        if (w_hs) state_nxt = OUT_B;
      end
      OUT_B: begin
        BREADY = 1'b1;
        if (b_bad)     state_nxt = FIN;
        else if (b_hs) state_nxt = out_last ? FIN : OUT_AR;
      end
      FIN: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Job parameters are only meaningful after an accepted start, so they carry no reset.
  always_ff @(posedge ACLK) begin
    if (state == IDLE && start) begin
      src_q       <= src_addr;
      dst_q       <= dst_addr;
      base_q      <= asic_base;
      in_words_q  <= in_words;
      out_words_q <= out_words;
    end
  end

  // Addresses are loaded one state ahead so they are valid in the first cycle of VALID.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      err     <= 1'b0;
      in_cnt  <= '0;
      out_cnt <= '0;
      ARADDR  <= '0;
      AWADDR  <= '0;
      WDATA   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          err     <= 1'b0;
          in_cnt  <= '0;
          out_cnt <= '0;
          ARADDR  <= (in_words != '0) ? src_addr : asic_base + OFMAP_OFS;
        end
        IN_R: if (r_hs) begin
          if (r_bad) err   <= 1'b1;
          else       WDATA <= RDATA;
          AWADDR <= base_q + DATA_OFS;
        end
        IN_B: if (b_hs) begin
          if (b_bad) err <= 1'b1;
          in_cnt <= in_cnt_inc;
          ARADDR <= in_last ? base_q + OFMAP_OFS : word_addr(src_q, ADDR_W'(in_cnt_inc));
        end
        OUT_R: if (r_hs) begin
          if (r_bad) err   <= 1'b1;
          else       WDATA <= RDATA;
          AWADDR <= word_addr(dst_q, ADDR_W'(out_cnt));
        end
        OUT_B: if (b_hs) begin
          if (b_bad) err <= 1'b1;
          out_cnt <= out_cnt_inc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_asic_dma_feeder.sv
// Bench for asic_dma_feeder: AXI memory/wrapper responder with optional random stalls,
// table-driven jobs checked against a word-level model of the expected transfers.
module tb_asic_dma_feeder;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0, asic_base = '0;
  logic [10:0] in_words = '0;
  logic [7:0]  out_words = '0;
  logic        asic_irq = 1'b1;
  logic        busy, done, err;
  logic [3:0]  AWID, ARID, AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST;
  logic [31:0] AWADDR, ARADDR, WDATA;
  logic [3:0]  WSTRB;
  logic        AWVALID, WVALID, WLAST, BREADY, ARVALID, RREADY;
  logic        AWREADY = 1'b0, WREADY = 1'b0, ARREADY = 1'b0;
  logic        BVALID = 1'b0, RVALID = 1'b0, RLAST = 1'b1;
  logic [3:0]  BID = 4'd0, RID = 4'd0;
  logic [1:0]  BRESP = 2'b00, RRESP = 2'b00;
  logic [31:0] RDATA = '0;

  asic_dma_feeder #(.ADDR_W(32), .DATA_W(32), .CNT_W(11)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .asic_base(asic_base), .in_words(in_words), .out_words(out_words), .asic_irq(asic_irq),
    .busy(busy), .done(done), .err(err),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  // Test-owned job context, read by the responder.
  int          job_gen = 0;
  bit          stall_en = 1'b0;
  int          berr_idx = -1, rerr_idx = -1;
  logic [31:0] cur_base = '0, seed = '0;

  // Responder-owned state.
  int          seen_gen = 0;
  logic [31:0] got_in[$];
  logic [31:0] wmem[logic [31:0]];
  int          n_ar = 0, n_aw = 0, n_of = 0, n_mw = 0, viol = 0;
  bit          rd_pend, b_pend, ar_hs, r_hs, aw_hs, w_hs, b_hs, p_arv, p_awv, p_wv;
  logic [31:0] rd_data, ar_a, aw_a, w_d, wa, p_ara, p_awa, p_wd;
  logic [1:0]  rd_resp, wr_resp;

  int n_cmp = 0, n_bad = 0;

  function automatic logic [31:0] memfun(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  function automatic logic [31:0] ofmap_word(input int k);
    return 32'hC0DE_0000 + 32'(k) * 32'h0001_0003;
  endfunction

  // Everything happens at the falling edge: retire the handshakes the last rising edge saw,
  // drive new slave outputs, then note which handshakes the next rising edge will see.
  always @(negedge ACLK) begin
    if (job_gen != seen_gen) begin
      seen_gen = job_gen;
      got_in.delete();
      wmem.delete();
      n_ar = 0; n_aw = 0; n_of = 0; n_mw = 0;
    end
    if (!ARESETn) begin
      rd_pend = 0; b_pend = 0; ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
      p_arv = 0; p_awv = 0; p_wv = 0;
      ARREADY = 0; AWREADY = 0; WREADY = 0; RVALID = 0; BVALID = 0;
      RDATA = '0; RRESP = 2'b00; BRESP = 2'b00;
    end else begin
      if (p_arv && !ar_hs && (!ARVALID || ARADDR != p_ara)) viol++;
      if (p_awv && !aw_hs && (!AWVALID || AWADDR != p_awa)) viol++;
      if (p_wv && !w_hs && (!WVALID || WDATA != p_wd)) viol++;
      if (AWVALID && WVALID) viol++;
      if (r_hs) begin RVALID = 0; rd_pend = 0; end
      if (ar_hs) begin
        n_ar++;
        if (ar_a == cur_base + 32'd8) begin rd_data = ofmap_word(n_of); n_of++; end
        else rd_data = memfun(ar_a);
        rd_resp = (n_ar - 1 == rerr_idx) ? 2'b10 : 2'b00;
        rd_pend = 1;
      end
      if (b_hs) begin BVALID = 0; b_pend = 0; end
      if (aw_hs) begin n_aw++; wa = aw_a; end
      if (w_hs) begin
        if (wa == cur_base + 32'd4) begin
          got_in.push_back(w_d);
          wr_resp = (got_in.size() - 1 == berr_idx) ? 2'b10 : 2'b00;
        end else begin
          wmem[wa] = w_d;
          n_mw++;
          wr_resp = 2'b00;
        end
        b_pend = 1;
      end
      ARREADY = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      AWREADY = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      WREADY  = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (rd_pend && !RVALID && (!stall_en || $urandom_range(0, 1) == 1)) begin
        RVALID = 1; RDATA = rd_data; RRESP = rd_resp;
      end
      if (b_pend && !BVALID && (!stall_en || $urandom_range(0, 1) == 1)) begin
        BVALID = 1; BRESP = wr_resp;
      end
      ar_hs = ARVALID && ARREADY; ar_a = ARADDR;
      r_hs  = RVALID && RREADY;
      aw_hs = AWVALID && AWREADY; aw_a = AWADDR;
      w_hs  = WVALID && WREADY;   w_d = WDATA;
      b_hs  = BVALID && BREADY;
      p_arv = ARVALID; p_ara = ARADDR;
      p_awv = AWVALID; p_awa = AWADDR;
      p_wv  = WVALID;  p_wd  = WDATA;
    end
  end

  typedef struct {
    int in_w; int out_w;
    logic [31:0] src; logic [31:0] dst; logic [31:0] base;
    int berr; int rerr;
    int lat; int err; int nin; int nout; int nar;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(negedge ACLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic launch(input vec_t v, input bit stall);
    stall_en = stall; berr_idx = v.berr; rerr_idx = v.rerr; cur_base = v.base; seed = $urandom;
    src_addr = v.src; dst_addr = v.dst; asic_base = v.base;
    in_words = 11'(v.in_w); out_words = 8'(v.out_w);
    job_gen++;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 60000) begin tick(); lat++; end
    check("done_seen", done, 1'b1);
    check("busy_at_done", busy, 1'b0);
  endtask

  task automatic check_results(input vec_t v);
    check("err_flag", err, v.err);
    check("done_pulse", done, 1'b0);
    check("ar_count", n_ar, v.nar);
    check("mem_writes", n_mw, v.nout);
    check("data_count", got_in.size(), v.nin);
    for (int i = 0; i < v.nin; i++)
      check("data_word", (i < got_in.size()) ? got_in[i] : 32'hxxxx_xxxx, memfun(v.src + 32'(4 * i)));
    for (int j = 0; j < v.nout; j++)
      check("ofmap_store", wmem.exists(v.dst + 32'(4 * j)) ? wmem[v.dst + 32'(4 * j)] : 32'hxxxx_xxxx,
            ofmap_word(j));
    check("proto_ok", viol, 0);
  endtask

  task automatic do_job(input vec_t v, input bit stall);
    int lat;
    launch(v, stall);
    check("busy_after_start", busy, (v.in_w != 0 || v.out_w != 0));
    check("err_cleared", err, 1'b0);
    wait_done(lat);
    if (v.lat >= 0) check("latency", lat, v.lat);
    tick();
    check_results(v);
  endtask

  initial begin
    vec_t v;
    int   lat, k;
    //           in  out  src            dst            base           berr rerr lat err nin nout nar
    tbl[0] = '{4,  2, 32'h0000_1000, 32'h0000_2000, 32'h8000_0000, -1, -1, 32, 0, 4, 2, 6};
    tbl[1] = '{0,  0, 32'h0000_1000, 32'h0000_2000, 32'h8000_0000, -1, -1,  1, 0, 0, 0, 0};
    tbl[2] = '{3,  0, 32'h0000_3000, 32'h0000_4000, 32'h4000_0000, -1, -1, 16, 0, 3, 0, 3};
    tbl[3] = '{0,  3, 32'h0000_3000, 32'h0000_5000, 32'h4000_0000, -1, -1, 17, 0, 0, 3, 3};
    tbl[4] = '{1,  2, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h8000_0000, -1, -1, 17, 0, 1, 2, 3};
    tbl[5] = '{6,  2, 32'h0000_1000, 32'h0000_2000, 32'h8000_0000,  3, -1, 21, 1, 4, 0, 4};
    tbl[6] = '{2,  1, 32'h0000_1000, 32'h0000_2000, 32'h8000_0000, -1,  1,  8, 1, 1, 0, 2};
    tbl[7] = '{2,  2, 32'h0000_1000, 32'h0000_2000, 32'h8000_0000, -1,  3, 19, 1, 2, 1, 4};

    ARESETn = 1'b0;
    repeat (3) tick();
    check("rst_ctrl", {busy, done, err, ARVALID, AWVALID, WVALID, BREADY, RREADY}, 8'h00);
    check("rst_araddr", ARADDR, 32'h0);
    check("rst_awaddr", AWADDR, 32'h0);
    check("rst_wdata", WDATA, 32'h0);
    check("const_fields", {AWID, ARID, AWLEN, ARLEN, AWSIZE, ARSIZE, AWBURST, ARBURST, WSTRB},
          {4'd0, 4'd0, 4'd0, 4'd0, 3'b010, 3'b010, 2'b01, 2'b01, 4'hF});
    ARESETn = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) do_job(tbl[i], 1'b0);

    // Random jobs with stalls on every channel.
    for (int r = 0; r < 6; r++) begin
      v.in_w = $urandom_range(0, 24); v.out_w = $urandom_range(0, 12);
      v.src = $urandom & 32'hFFFF_FFFC;
      v.dst = 32'h0010_0000 + 32'($urandom_range(0, 1023) << 2);
      v.base = 32'hA000_0000; v.berr = -1; v.rerr = -1; v.lat = -1; v.err = 0;
      v.nin = v.in_w; v.nout = v.out_w; v.nar = v.in_w + v.out_w;
      do_job(v, 1'b1);
    end

    // Long stalled job.
    v = '{1104, 64, 32'h0002_0000, 32'h0040_0000, 32'h8000_0000, -1, -1, -1, 0, 1104, 64, 1168};
    do_job(v, 1'b1);

    // Interrupt held low: no OFMAP traffic, extra starts ignored, busy stays high.
    asic_irq = 1'b0;
    v = '{3, 2, 32'h0000_6000, 32'h0000_7000, 32'h8000_0000, -1, -1, -1, 0, 3, 2, 5};
    launch(v, 1'b0);
    k = 0;
    for (int c = 0; c < 500; c++) begin
      if (c == 100 || c == 300) begin
        src_addr = 32'h0000_9000; in_words = 11'd7; start = 1'b1;
      end
      tick();
      start = 1'b0;
      if (!busy) k++;
    end
    check("irq_wait_busy", k, 0);
    check("irq_wait_no_ofmap", n_of, 0);
    check("irq_wait_ar", n_ar, 3);
    asic_irq = 1'b1;
    wait_done(lat);
    tick();
    check_results(v);

    // Reset in the middle of an output write.
    v = '{2, 2, 32'h0000_1000, 32'h0000_2000, 32'h8000_0000, -1, -1, -1, 0, 2, 2, 4};
    launch(v, 1'b0);
    k = 0;
    while (!(WVALID && n_of > 0) && k < 200) begin tick(); k++; end
    check("reach_out_w", WVALID && n_of > 0, 1'b1);
    ARESETn = 1'b0;
    tick();
    check("midrst_ctrl", {busy, done, err, ARVALID, AWVALID, WVALID, BREADY, RREADY}, 8'h00);
    check("midrst_addr", {ARADDR, AWADDR}, 64'h0);
    check("midrst_wdata", WDATA, 32'h0);
    ARESETn = 1'b1;
    tick();
    do_job(tbl[1], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/asic_dma_feeder.md
# asic_dma_feeder

DMA engine on the AXI master side that feeds the transformer ASIC wrapper. It streams an input image (ifmap, weights, bias words) word by word from system memory into the wrapper's DATA register. It then waits for the ASIC interrupt, drains the wrapper's OFMAP register and writes the result back to memory. It replaces CPU-driven MMIO loops and uses a single AXI4 master port with one outstanding single-beat transaction at a time.

## Interface
Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, AXI data width; one word per beat.
- CNT_W, 11, width of input word counter (max 2047 words).

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  reset: synchronous, active-low; clock ACLK.
- start  in  1  one-cycle pulse; launches a job when idle, ignored while busy.
- src_addr  in  32  memory address of first input word; latched at start.
- dst_addr  in  32  memory address for first output word; latched at start.
- asic_base  in  32  wrapper base address (ENABLE +0x00, DATA +0x04, OFMAP +0x08); latched.
- in_words  in  CNT_W  number of input words to push; latched.
- out_words  in  8  number of ofmap words to drain; latched.
- asic_irq  in  1  wrapper interrupt, level.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse at job end.
- err  out  1  sticky error flag; cleared on the next accepted start.
- AWID/ARID  out  4  constant 0.
- AWADDR/ARADDR  out  32  transaction address.
- AWLEN/ARLEN  out  4  constant 0.
- AWSIZE/ARSIZE  out  3  constant 3'b010.
- AWBURST/ARBURST  out  2  constant INCR (2'b01).
- AWVALID/ARVALID/WVALID/BREADY/RREADY  out  1  channel handshakes.
- AWREADY/ARREADY/WREADY/BVALID/RVALID/RLAST  in  1  channel handshakes.
- WDATA  out  32  write data.
- WSTRB  out  4  constant 4'hF.
- WLAST  out  1  equals WVALID.
- BID  in  4  write response ID; ignored.
- BRESP  in  2  write response.
- RID  in  4  read response ID; ignored.
- RDATA  in  32  read data.
- RRESP  in  2  read response.

## Operation
- FSM states: IDLE, IN_AR, IN_R, IN_AW, IN_W, IN_B, WAIT_IRQ, OUT_AR, OUT_R, OUT_AW, OUT_W, OUT_B, FIN.
- IDLE: on start, latch all job inputs, clear err, zero in_cnt/out_cnt. Go to IN_AR if in_words≠0; else WAIT_IRQ if out_words≠0; else FIN.
- Input loop, one word per pass:
  - IN_AR reads src_addr+4·in_cnt from memory.
  - IN_R captures RDATA into a word register.
  - IN_AW addresses asic_base+0x04.
  - IN_W drives the word register on WDATA.
  - IN_B waits for BVALID; in_cnt increments on B handshake.
  - After the B handshake of word in_words−1, go to WAIT_IRQ (or FIN if out_words=0); otherwise return to IN_AR.
- AW is always handshaked before W is asserted; W is never issued in the same cycle as AW.
- WAIT_IRQ: stay until asic_irq=1 is sampled, then go to OUT_AR. asic_irq is ignored in all other states.
- Output loop:
  - OUT_AR reads asic_base+0x08.
  - OUT_R captures RDATA.
  - OUT_AW addresses dst_addr+4·out_cnt.
  - OUT_W drives the captured word.
  - OUT_B waits for BVALID; out_cnt increments on B handshake.
  - After word out_words−1, go to FIN.
- FIN: done=1 for one cycle, busy=0, next state IDLE.
- Errors: RRESP≠OKAY on an R handshake, or BRESP≠OKAY on a B handshake, sets err and jumps directly to FIN. No further transactions are issued.
- Address arithmetic is modulo 2^32 (natural wrap), computed as base + (cnt<<2).

## Timing
- Reset values: all VALID outputs 0, BREADY 0, RREADY 0, busy 0, done 0, err 0, AWADDR/ARADDR/WDATA 0, FSM IDLE.
- Reset mid-job aborts immediately; any in-flight transaction is abandoned without completion.
- VALID rises in the first cycle of its state and holds, with ADDR/DATA stable, until the handshake cycle. The FSM advances on the cycle after the handshake.
- RREADY is high only in IN_R/OUT_R; BREADY is high only in IN_B/OUT_B.
- With zero-wait slaves: 5 cycles per input word and 5 cycles per output word. Job latency = 1 + 5·in_words + irq wait + 5·out_words + 1.
- busy asserts the cycle after start; done and the busy deassertion coincide in FIN.
- A start arriving in the FIN cycle is ignored.

## Test plan
- Zero-wait memory and wrapper model, in_words=4, out_words=2, src 0x1000, dst 0x2000, asic_base 0x8000_0000:
  - Expect 4 DATA writes of mem[0x1000..0x100C] to 0x8000_0004.
  - Expect 2 OFMAP reads, stored at 0x2000/0x2004.
  - done after exactly 32 cycles + irq wait.
- Random AWREADY/WREADY/ARREADY/RVALID/BVALID stalls, in_words=1104, out_words=64: wrapper receives all 1104 words in order; ADDR/DATA stable while VALID high.
- irq held low for 500 cycles: no OFMAP read issued until irq=1; start pulses during the wait are ignored and busy stays high.
- Wrapper returns BRESP=SLVERR on input word 3: err=1 and done pulses; no AR issued after it; a new start clears err.
- in_words=0, out_words=0: done 2 cycles after start with no AXI traffic. Also: ARESETn low mid-OUT_W gives all outputs 0 and the FSM in IDLE the next cycle.
